// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
//   INST_W / ADDR_W : instruction and address widths
//   RESET_PC_DEF    : boot vector loaded into the PC on reset
//   PC_INC_DEF      : sequential fetch increment
//   if_state_t      : fetch-stage FSM states
package mips_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [ADDR_W-1:0] PC_INC_DEF   = 32'd4;

    // StFetch: live request at pc; StDrop: stale request whose data is
    // discarded; StHold: one instruction buffered while decode stalls.
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StDrop  = 2'd1,
        StHold  = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus.
//   inst_req   : fetch request (master -> slave)
//   inst_addr  : word-aligned fetch address (master -> slave)
//   inst_ack   : data returned for the outstanding request (slave -> master)
//   inst_rdata : instruction word, valid with inst_ack (slave -> master)
interface if_stage_if;
    import mips_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ack;
    logic [INST_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : discard the held instruction (redirect)
//   stall             : decode cannot accept; hold contents
//   load              : a new instruction is presented this cycle
//   load_inst/load_pc : the instruction and its address
//   id_valid/id_inst/id_pc/id_pc_plus4 : register contents to decode
module if_id_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              load,
    input  logic [INST_W-1:0] load_inst,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4
);

    // Load is only raised by the fetch stage when decode can take it (not
    // stalled, or the register is empty), so it may override stall here.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_inst     <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_inst     <= load_inst;
            id_pc       <= load_pc;
            id_pc_plus4 <= load_pc + 32'd4;
        end else if (!stall) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory bus,
// buffers one instruction while decode stalls and flushes on redirect.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : decode cannot accept a new instruction
//   redirect          : taken branch/jump from decode
//   redirect_pc       : redirect target
//   imem              : instruction-memory bus (master side)
//   id_valid/id_inst/id_pc/id_pc_plus4 : IF/ID register outputs
module if_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [ADDR_W-1:0] PC_INC   = PC_INC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    if_stage_if.master        imem,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4
);

    if_state_t         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pending_pc_q;
    logic [INST_W-1:0] buf_inst_q;
    logic [ADDR_W-1:0] buf_pc_q;

    logic              ack;
    logic              load;
    logic [INST_W-1:0] load_inst;
    logic [ADDR_W-1:0] load_pc;

    // The request is withdrawn during reset so a late ack cannot land.
    assign imem.inst_req  = !rst && (state_q != StHold);
    assign imem.inst_addr = {pc_q[ADDR_W-1:2], 2'b00};
    assign ack            = imem.inst_req && imem.inst_ack;

    always_comb begin
        load      = 1'b0;
        load_inst = imem.inst_rdata;
        load_pc   = pc_q;
        unique case (state_q)
            StFetch: load = ack && !redirect && (!stall || !id_valid);
            StHold: begin
                load      = !redirect && !stall;
                load_inst = buf_inst_q;
                load_pc   = buf_pc_q;
            end
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            pending_pc_q <= '0;
            buf_inst_q   <= '0;
            buf_pc_q     <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (ack) begin
                        if (redirect) begin
                            pc_q <= redirect_pc;
                        end else begin
                            pc_q <= pc_q + PC_INC;
                            if (stall && id_valid) begin
                                buf_inst_q <= imem.inst_rdata;
                                buf_pc_q   <= pc_q;
                                state_q    <= StHold;
                            end
                        end
                    end else if (redirect) begin
                        // Request cannot be withdrawn; wait it out in StDrop.
                        pending_pc_q <= redirect_pc;
                        state_q      <= StDrop;
                    end
                end
                StDrop: begin
                    if (redirect) begin
                        pending_pc_q <= redirect_pc;
                    end
                    if (ack) begin
                        pc_q    <= redirect ? redirect_pc : pending_pc_q;
                        state_q <= StFetch;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        buf_inst_q <= '0;
                        buf_pc_q   <= '0;
                        pc_q       <= redirect_pc;
                        state_q    <= StFetch;
                    end else if (!stall) begin
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect),
        .stall       (stall),
        .load        (load),
        .load_inst   (load_inst),
        .load_pc     (load_pc),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    if_stage_if bus ();

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: fetch pointer, a "stale request" flag with its
    // deferred target, a one-slot parking spot, and decode's view.
    logic [31:0] m_pc, m_tgt, m_pinst, m_ppc;
    bit          m_stale, m_parked;
    bit          m_idv;
    logic [31:0] m_idi, m_idp, m_idp4;

    bit          c_rst, c_stall, c_redir, c_ack;
    logic [31:0] c_rpc, c_rdata;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          got, ld;
        logic [31:0] li, lp;
        if (c_rst) begin
            m_pc = 32'hBFC0_0000; m_tgt = 0; m_stale = 0; m_parked = 0;
            m_pinst = 0; m_ppc = 0;
            m_idv = 0; m_idi = 0; m_idp = 0; m_idp4 = 0;
            return;
        end
        got = !m_parked && c_ack;
        ld  = 0; li = 0; lp = 0;
        if (m_parked) begin
            if (c_redir) begin
                m_parked = 0; m_pc = c_rpc;
            end else if (!c_stall) begin
                ld = 1; li = m_pinst; lp = m_ppc; m_parked = 0;
            end
        end else if (m_stale) begin
            if (c_redir) m_tgt = c_rpc;
            if (got) begin
                m_pc = m_tgt; m_stale = 0;
            end
        end else if (got) begin
            if (c_redir) m_pc = c_rpc;
            else if (!c_stall || !m_idv) begin
                ld = 1; li = c_rdata; lp = m_pc; m_pc = m_pc + 4;
            end else begin
                m_parked = 1; m_pinst = c_rdata; m_ppc = m_pc; m_pc = m_pc + 4;
            end
        end else if (c_redir) begin
            m_stale = 1; m_tgt = c_rpc;
        end
        if (c_redir) m_idv = 0;
        else if (ld) begin
            m_idv = 1; m_idi = li; m_idp = lp; m_idp4 = lp + 4;
        end else if (!c_stall) m_idv = 0;
    endtask

    // Apply inputs just after an edge and check the bus before the next edge.
    task automatic drive(input bit r, input bit s, input bit rd, input logic [31:0] rpc,
                         input bit a, input logic [31:0] rdat);
        bit exp_req;
        c_rst = r; c_stall = s; c_redir = rd; c_rpc = rpc; c_ack = a; c_rdata = rdat;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        bus.inst_ack = a; bus.inst_rdata = rdat;
        #3;
        exp_req = !r && !m_parked;
        chk("inst_req", {31'd0, bus.inst_req}, {31'd0, exp_req});
        if (exp_req) chk("inst_addr", bus.inst_addr, {m_pc[31:2], 2'b00});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_idv});
        chk("id_inst", id_inst, m_idi);
        chk("id_pc", id_pc, m_idp);
        chk("id_pc_plus4", id_pc_plus4, m_idp4);
    endtask

    initial begin
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
        bus.inst_ack = 0; bus.inst_rdata = 0;
        @(posedge clk);
        #1;

        // Reset with a stray ack present.
        drive(1, 0, 0, 0, 1, 32'h1111_1111); tick();
        chk("rst_id_pc", id_pc, 32'h0);

        // Sequential fetch, then a stalled ack that parks into the buffer.
        drive(0, 0, 0, 0, 1, mem(32'hBFC0_0000));
        chk("plan_addr0", bus.inst_addr, 32'hBFC0_0000); tick();
        drive(0, 1, 0, 0, 1, mem(32'hBFC0_0004));
        chk("plan_addr1", bus.inst_addr, 32'hBFC0_0004); tick();
        chk("hold_id_pc", id_pc, 32'hBFC0_0000);
        drive(0, 1, 0, 0, 0, 0);
        chk("hold_no_req", {31'd0, bus.inst_req}, 32'd0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("release_id_pc", id_pc, 32'hBFC0_0004);

        // Redirect in the ack cycle.
        drive(0, 0, 1, 32'h8000_0100, 1, mem(32'hBFC0_0008));
        chk("plan_addr2", bus.inst_addr, 32'hBFC0_0008); tick();
        chk("redir_flush", {31'd0, id_valid}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("redir_addr", bus.inst_addr, 32'h8000_0100); tick();
        drive(0, 0, 0, 0, 1, mem(32'h8000_0100)); tick();

        // Slow ack with a redirect in the first wait cycle.
        drive(0, 0, 1, 32'h8000_0200, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("drop_addr_stable", bus.inst_addr, 32'h8000_0104); tick();
        drive(0, 0, 0, 0, 1, mem(32'h8000_0104)); tick();
        chk("drop_discard", {31'd0, id_valid}, 32'd0);
        drive(0, 0, 0, 0, 1, mem(32'h8000_0200));
        chk("drop_target", bus.inst_addr, 32'h8000_0200); tick();

        // Redirect together with stall while valid: flush wins.
        drive(0, 1, 1, 32'hFFFF_FFFC, 0, 0); tick();
        chk("flush_wins", {31'd0, id_valid}, 32'd0);
        drive(0, 0, 0, 0, 1, 32'h0); tick();

        // Address wrap at the top of memory.
        drive(0, 0, 0, 0, 1, mem(32'hFFFF_FFFC));
        chk("wrap_addr", bus.inst_addr, 32'hFFFF_FFFC); tick();
        chk("wrap_plus4", id_pc_plus4, 32'h0);
        drive(0, 0, 0, 0, 1, mem(32'h0));
        chk("wrap_next", bus.inst_addr, 32'h0); tick();

        // Reset while a stale request is outstanding.
        drive(0, 0, 1, 32'h8000_0300, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 32'h2222_2222); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_drop_addr", bus.inst_addr, 32'hBFC0_0000);
        chk("rst_drop_valid", {31'd0, id_valid}, 32'd0); tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit          r, s, rd, a;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 15);
            a   = ($urandom_range(0, 99) < 55);
            rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive(r, s, rd, rpc, a, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
